// File: rtl/basic_pipe_reg.sv
// Elastic multi-stage pipeline register with valid/ready flow control, bubble collapsing,
// synchronous flush and registered occupancy. Define BASIC_PIPE_REG_NEGEDGE_EN to capture on falling CLK.
module basic_pipe_reg #(
    parameter int unsigned    DW      = 32,
    parameter int unsigned    DEPTH   = 2,
    parameter logic [DW-1:0]  RST_VAL = '0,
    localparam int unsigned   CW      = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] occupancy
);

    logic [DEPTH-1:0] r_vld;
    logic [DW-1:0]    r_dat [DEPTH];
    logic [CW-1:0]    r_occ;

    logic [DEPTH-1:0] w_rdy;
    logic [DEPTH-1:0] w_up_vld;
    logic [DW-1:0]    w_up_dat [DEPTH];
    logic [DEPTH-1:0] w_vld_nxt;
    logic [DEPTH-1:0] w_load;
    logic [CW-1:0]    w_occ_nxt;

    // Ready ripples from the output stage back; an empty stage is always ready.
    always_comb begin
        w_rdy = '0;
        w_rdy[DEPTH-1] = !r_vld[DEPTH-1] | out_ready;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            w_rdy[i] = !r_vld[i] | w_rdy[i+1];
        end
    end

    always_comb begin
        w_up_vld  = '0;
        w_up_dat  = '{default: '0};
        w_vld_nxt = '0;
        w_load    = '0;
        w_occ_nxt = '0;
        w_up_vld[0] = in_valid;
        w_up_dat[0] = in_data;
        for (int i = 1; i < int'(DEPTH); i++) begin
            w_up_vld[i] = r_vld[i-1];
            w_up_dat[i] = r_dat[i-1];
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (flush) begin
                w_vld_nxt[i] = 1'b0;
            end else if (w_rdy[i]) begin
                w_vld_nxt[i] = w_up_vld[i];
            end else begin
                w_vld_nxt[i] = r_vld[i];
            end
            // Data only moves with a valid word so bubbles never toggle the data path.
            w_load[i] = !flush & w_rdy[i] & w_up_vld[i];
            w_occ_nxt = w_occ_nxt + CW'(w_vld_nxt[i]);
        end
    end

`ifdef BASIC_PIPE_REG_NEGEDGE_EN
    always_ff @(negedge CLK or posedge RST) begin
`else
    always_ff @(posedge CLK or posedge RST) begin
`endif
        if (RST) begin
            r_vld <= '0;
            r_occ <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_dat[i] <= RST_VAL;
            end
        end else begin
            r_vld <= w_vld_nxt;
            r_occ <= w_occ_nxt;
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (w_load[i]) begin
                    r_dat[i] <= w_up_dat[i];
                end
            end
        end
    end

    assign in_ready  = w_rdy[0] & !flush;
    assign out_valid = r_vld[DEPTH-1];
    assign out_data  = r_dat[DEPTH-1];
    assign occupancy = r_occ;

endmodule

// File: tb/tb_basic_pipe_reg.sv
// Directed bench for basic_pipe_reg: a DEPTH=3 instance driven from a vector table and a
// DEPTH=2 instance for the streaming and asynchronous reset sequences.
module tb_basic_pipe_reg;

    localparam logic [7:0] RV = 8'hEE;

    logic       CLK = 1'b0;
    logic       RST;
    logic       flush;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data;

    logic       ir2, ov2, ir3, ov3;
    logic [7:0] od2, od3;
    logic [1:0] occ2, occ3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    basic_pipe_reg #(.DW(8), .DEPTH(2), .RST_VAL(RV)) u2 (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .occupancy(occ2)
    );

    basic_pipe_reg #(.DW(8), .DEPTH(3), .RST_VAL(RV)) u3 (
        .CLK(CLK), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
        .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .occupancy(occ3)
    );

    typedef struct packed {
        logic       fl;
        logic       iv;
        logic [7:0] id;
        logic       orr;
        logic       ir;
        logic       ov;
        logic [7:0] od;
        logic [1:0] occ;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Active capture edge of the design, then settle.
    task automatic tick();
`ifdef BASIC_PIPE_REG_NEGEDGE_EN
        @(negedge CLK);
`else
        @(posedge CLK);
`endif
        #1;
    endtask

    task automatic tick_opp();
`ifdef BASIC_PIPE_REG_NEGEDGE_EN
        @(posedge CLK);
`else
        @(negedge CLK);
`endif
        #1;
    endtask

    initial begin
        //            fl    iv    id     or    ir    ov    od     occ
        vecs[0]  = '{1'b0, 1'b1, 8'h0A, 1'b0, 1'b1, 1'b0, RV,    2'd1};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, RV,    2'd1};
        vecs[2]  = '{1'b0, 1'b1, 8'h0B, 1'b0, 1'b1, 1'b1, 8'h0A, 2'd2};
        vecs[3]  = '{1'b0, 1'b1, 8'h0C, 1'b0, 1'b1, 1'b1, 8'h0A, 2'd3};
        vecs[4]  = '{1'b0, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b1, 8'h0A, 2'd3};
        vecs[5]  = '{1'b0, 1'b1, 8'h0D, 1'b1, 1'b1, 1'b1, 8'h0B, 2'd3};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h0C, 2'd2};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h0D, 2'd1};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h0D, 2'd0};
        vecs[9]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h0D, 2'd1};
        vecs[10] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h0D, 2'd2};
        vecs[11] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h0D, 2'd0};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h0D, 2'd0};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h0D, 2'd0};
        vecs[14] = '{1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 8'h0D, 2'd1};
        vecs[15] = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 8'h0D, 2'd2};
        vecs[16] = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h01, 2'd3};
        vecs[17] = '{1'b0, 1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 8'h02, 2'd3};
        vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, 2'd3};
        vecs[19] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 2'd2};
        vecs[20] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h03, 2'd0};
        vecs[21] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h03, 2'd0};

        // Reset with a pending input word.
        RST = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(ov3), 32'd0);
        chk("rst_out_data", 32'(od3), 32'(RV));
        chk("rst_occupancy", 32'(occ3), 32'd0);
        chk("rst_in_ready", 32'(ir3), 32'd1);
        chk("rst_out_valid_d2", 32'(ov2), 32'd0);
        tick();
        chk("rst_hold_occupancy", 32'(occ3), 32'd0);
        chk("rst_hold_out_valid", 32'(ov3), 32'd0);
        RST = 1'b0; in_valid = 1'b0;
        tick();
        chk("post_rst_out_valid", 32'(ov3), 32'd0);
        chk("post_rst_occupancy", 32'(occ3), 32'd0);

        // Backpressure, bubble collapse, full pass-through, flush and stream on DEPTH=3.
        for (int i = 0; i < 22; i++) begin
            flush = vecs[i].fl; in_valid = vecs[i].iv;
            in_data = vecs[i].id; out_ready = vecs[i].orr;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(ir3), 32'(vecs[i].ir));
            tick();
            chk($sformatf("v%0d_out_valid", i), 32'(ov3), 32'(vecs[i].ov));
            chk($sformatf("v%0d_out_data", i), 32'(od3), 32'(vecs[i].od));
            chk($sformatf("v%0d_occupancy", i), 32'(occ3), 32'(vecs[i].occ));
        end

        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        RST = 1'b1; #1; RST = 1'b0;

        // Stream on DEPTH=2: first word appears after the second capture.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            in_data = 8'(k);
            #1;
            chk($sformatf("s%0d_in_ready", k), 32'(ir2), 32'd1);
            tick();
            if (k == 1) begin
                chk("s1_out_valid", 32'(ov2), 32'd0);
                chk("s1_occupancy", 32'(occ2), 32'd1);
            end else begin
                chk($sformatf("s%0d_out_valid", k), 32'(ov2), 32'd1);
                chk($sformatf("s%0d_out_data", k), 32'(od2), 32'(k - 1));
                chk($sformatf("s%0d_occupancy", k), 32'(occ2), 32'd2);
            end
        end

        // Asynchronous reset between edges while DEPTH=2 holds two words.
        in_valid = 1'b0;
        #1 RST = 1'b1;
        #1;
        chk("arst_out_valid", 32'(ov2), 32'd0);
        chk("arst_occupancy", 32'(occ2), 32'd0);
        chk("arst_out_data", 32'(od2), 32'(RV));
        #1 RST = 1'b0;

        // Captures happen only on the configured clock edge.
        in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
        tick_opp();
        chk("opp_edge_occupancy", 32'(occ3), 32'd0);
        tick();
        chk("act_edge_occupancy", 32'(occ3), 32'd1);
        in_valid = 1'b0;
        tick();
        tick();
        chk("act_edge_out_valid", 32'(ov3), 32'd1);
        chk("act_edge_out_data", 32'(od3), 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
